// File: rtl/bpu_update_unit.sv
// bpu_update_unit: queues resolved-branch reports from the backend and
// turns each one into BHT/BTB training writes, after a reset-time BTB sweep.
// Ports:
//   clock, reset      - clock and asynchronous active-high reset
//   upd_valid/ready   - resolved-branch report handshake (pc, taken, target)
//   wr_hold           - BPU write ports busy; stalls sweep and drain
//   bht_write_*       - BHT counter update port (registered)
//   btb_*             - BTB masked write port (registered)
//   init_done         - BTB invalidation sweep finished
//   upd_issued_count  - reports drained to the BPU (wraps at 2^32)
module bpu_update_unit #(
   parameter int DEPTH       = 4,
   parameter int SETS        = 512,
   parameter int INDEX_WIDTH = 9
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   upd_valid,
   output logic                   upd_ready,
   input  logic [63:0]            upd_pc,
   input  logic                   upd_taken,
   input  logic [31:0]            upd_target,
   input  logic                   wr_hold,
   output logic                   bht_write_enable,
   output logic [INDEX_WIDTH-1:0] bht_write_index,
   output logic [1:0]             bht_write_counter_select,
   output logic                   bht_write_inc,
   output logic                   bht_write_dec,
   output logic                   bht_valid_in,
   output logic                   btb_ce,
   output logic                   btb_we,
   output logic [128:0]           btb_wmask,
   output logic [INDEX_WIDTH-1:0] btb_write_index,
   output logic [128:0]           btb_din,
   output logic                   init_done,
   output logic [31:0]            upd_issued_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = INDEX_WIDTH + 2;

   typedef enum logic {SWEEP, RUN} state_t;

   // pc keeps only set index and slot select: pc[INDEX_WIDTH+3:2]
   typedef struct packed {
      logic [PW-1:0] pc;
      logic          taken;
      logic [31:0]   target;
   } entry_t;

   state_t                 state_q, state_d;
   logic [INDEX_WIDTH-1:0] sweep_idx_q, sweep_idx_d;
   entry_t                 mem [DEPTH];
   entry_t                 head;
   logic [AW:0]            wr_ptr_q, rd_ptr_q;
   logic                   full, empty, push, pop, sweep_step;
   logic [6:0]             slot_shift;
   logic [127:0]           slot_mask, slot_data;

   logic                   bht_en_d, bht_inc_d, bht_dec_d, btb_wr_d;
   logic [INDEX_WIDTH-1:0] bht_idx_d, btb_idx_d;
   logic [1:0]             bht_sel_d;
   logic [128:0]           wmask_d, din_d;
   logic                   unused_pc;

   assign unused_pc = ^{upd_pc[63:INDEX_WIDTH+4], upd_pc[1:0]};

   // extra pointer bit tells full from empty
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign upd_ready = !full;
   assign push      = upd_valid && !full;
   assign head      = mem[rd_ptr_q[AW-1:0]];

   assign slot_shift = {head.pc[1:0], 5'd0};
   assign slot_mask  = {96'd0, 32'hFFFF_FFFF} << slot_shift;
   assign slot_data  = {96'd0, head.target} << slot_shift;

   always_comb begin
      state_d     = state_q;
      sweep_idx_d = sweep_idx_q;
      sweep_step  = 1'b0;
      pop         = 1'b0;
      bht_en_d    = 1'b0;
      bht_inc_d   = 1'b0;
      bht_dec_d   = 1'b0;
      btb_wr_d    = 1'b0;
      bht_idx_d   = bht_write_index;
      bht_sel_d   = bht_write_counter_select;
      btb_idx_d   = btb_write_index;
      wmask_d     = '0;
      din_d       = '0;
      unique case (state_q)
         SWEEP:   sweep_step = !wr_hold;
         RUN:     pop = !wr_hold && !empty;
         default: ;
      endcase
      unique case (1'b1)
         sweep_step: begin
            btb_wr_d    = 1'b1;
            btb_idx_d   = sweep_idx_q;
            wmask_d     = '1;
            sweep_idx_d = sweep_idx_q + INDEX_WIDTH'(1);
            if (sweep_idx_q == INDEX_WIDTH'(SETS - 1))
               state_d = RUN;
         end
         pop: begin
            bht_en_d  = 1'b1;
            bht_idx_d = head.pc[PW-1:2];
            bht_sel_d = head.pc[1:0];
            bht_inc_d = head.taken;
            bht_dec_d = !head.taken;
            if (head.taken) begin
               btb_wr_d  = 1'b1;
               btb_idx_d = head.pc[PW-1:2];
               wmask_d   = {1'b1, slot_mask};
               din_d     = {1'b1, slot_data};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= SWEEP;
         sweep_idx_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         sweep_idx_q <= sweep_idx_d;
         if (push)
            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr_q[AW-1:0]] <= {upd_pc[INDEX_WIDTH+3:2], upd_taken, upd_target};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bht_write_enable         <= 1'b0;
         bht_write_index          <= '0;
         bht_write_counter_select <= '0;
         bht_write_inc            <= 1'b0;
         bht_write_dec            <= 1'b0;
         bht_valid_in             <= 1'b0;
         btb_ce                   <= 1'b0;
         btb_we                   <= 1'b0;
         btb_wmask                <= '0;
         btb_write_index          <= '0;
         btb_din                  <= '0;
         init_done                <= 1'b0;
         upd_issued_count         <= '0;
      end else begin
         bht_write_enable         <= bht_en_d;
         bht_write_index          <= bht_idx_d;
         bht_write_counter_select <= bht_sel_d;
         bht_write_inc            <= bht_inc_d;
         bht_write_dec            <= bht_dec_d;
         bht_valid_in             <= bht_en_d;
         btb_ce                   <= btb_wr_d;
         btb_we                   <= btb_wr_d;
         btb_wmask                <= wmask_d;
         btb_write_index          <= btb_idx_d;
         btb_din                  <= din_d;
         // one cycle behind the state so it rises after the last sweep write
         init_done                <= (state_q == RUN);
         if (pop)
            upd_issued_count <= upd_issued_count + 32'd1;
      end
   end
endmodule
